ram_frame_arbiter: RTL
======================

Name: ram_frame_arbiter

Overview:
- Shares the ping-pong RAM read port between two frame consumers: requester A (I2S loopback transmitter) and requester B (FFT).
- Each full buffer announced by the RAM is granted whole, all FRAME_LEN samples, to exactly one requester.
- Grants alternate round-robin between the two requesters.
- If no consumer is requesting, the frame is drained and discarded so the RAM never stalls.
- Sits between the RAM read interface and the two consumers.

Parameters:
- FRAME_LEN, 256: samples per buffer; beats per grant.
- DATA_W, 32: RAM read data width.
- TIMEOUT_CYCLES, 4096: watchdog stall limit. Used only with the optional feature.

Ports:
- clk_i, in, 1: system clock.
- rst_ni, in, 1: asynchronous active-low reset.
- buffer_ready_i, in, 1: one-cycle pulse from RAM; a full buffer is readable.
- ram_data_i, in, DATA_W: RAM read data.
- ram_valid_i, in, 1: RAM read data valid.
- ram_ready_o, out, 1: read accept toward RAM.
- a_req_i, in, 1: requester A wants the next frame (level).
- a_grant_o, out, 1: A owns the current frame.
- a_data_o, out, DATA_W: data to A.
- a_valid_o, out, 1: valid to A.
- a_ready_i, in, 1: A accepts.
- b_req_i, b_grant_o, b_data_o, b_valid_o, b_ready_i: same as the A signals, for requester B.
- frame_start_o, out, 1: first beat of a frame is transferring.
- frame_last_o, out, 1: last beat of a frame is transferring.
- frame_drop_o, out, 1: one-cycle pulse when a frame is discarded.
- drop_count_o, out, 8: saturating count of discarded frames.
- busy_o, out, 1: high when not in IDLE.
- timeout_o, out, 1: one-cycle watchdog pulse. Tied 0 without the optional feature.

Behaviour:
- Reset: FSM goes to IDLE. The pending flag, beat counter and drop_count_o clear to 0. The round-robin pointer resets to favour A.
  - All outputs are 0.
  - a_data_o and b_data_o mirror ram_data_i combinationally at all times.
- States: IDLE, ARB, STREAM, DRAIN.
- IDLE:
  - On buffer_ready_i, or with the pending flag set, go to ARB next cycle and clear pending.
- ARB (one cycle):
  - Only one requester high: grant it.
  - Both high: grant the one not granted last.
  - Neither high: go to DRAIN and pulse frame_drop_o.
  - Grant is registered; x_grant_o rises on entry to STREAM.
- STREAM:
  - Zero-latency passthrough: owner's valid = ram_valid_i; ram_ready_o = owner's ready. Non-owner valid = 0.
  - A beat is ram_valid_i & ram_ready_o.
  - The beat counter increments per beat, 0..FRAME_LEN-1.
  - frame_start_o = beat & count==0. frame_last_o = beat & count==FRAME_LEN-1.
  - On the last beat, update the round-robin pointer and drop the grant next cycle.
  - Next state after the last beat: ARB if pending is set, else IDLE.
  - Requester deasserting req mid-frame has no effect; the grant is held until the last beat.
- DRAIN:
  - ram_ready_o = 1, no consumer valids.
  - Counts FRAME_LEN beats, then goes to ARB if pending is set, else IDLE.
- buffer_ready_i arriving outside IDLE:
  - Pending clear: set pending.
  - Pending already set: frame is lost. Pulse frame_drop_o; pending stays set.
- drop_count_o increments on every frame_drop_o pulse and saturates at 255.
  - Two drop events in one cycle increment it by 2, still saturating.
- buffer_ready_i coinciding with the last beat: pending is set and the FSM goes to ARB.
- Counter width is clog2(FRAME_LEN). Wrap back to 0 happens only at a frame end.
- Reset asserted mid-frame: immediate return to IDLE. The partial frame is abandoned and there is no drop pulse.

Optional Feature:
- Macro: RAM_FRAME_ARB_WATCHDOG_EN.
- Defined:
  - In STREAM, a stall counter counts consecutive cycles with ram_valid_i=1 and owner ready=0.
  - When the counter reaches TIMEOUT_CYCLES: pulse timeout_o and frame_drop_o, drop the grant, and move to DRAIN for the remaining beats only. The beat counter is preserved.
  - The round-robin pointer advances past the stalled owner.
  - Any beat clears the stall counter.
- Undefined: no stall counter; timeout_o is constant 0; STREAM waits indefinitely.

Test Plan:
1. Only a_req_i=1 with ready always 1, one buffer_ready_i pulse → a_grant_o high for exactly 256 beats. frame_start_o on beat 0, frame_last_o on beat 255. b_valid_o stays 0 throughout.
2. Both requests high, 4 buffer_ready_i pulses spaced 300 cycles apart → grants go A, B, A, B. drop_count_o=0.
3. No requests, one buffer_ready_i pulse → DRAIN with ram_ready_o=1 for 256 beats. One frame_drop_o pulse; drop_count_o=1.
4. A granted with a_ready_i toggling 50%, and two extra buffer_ready_i pulses during STREAM → first extra pulse sets pending, second pulses frame_drop_o. After A's last beat, next ARB occurs with no idle cycle.
5. Assert rst_ni=0 at beat 100 of a grant → outputs 0 immediately. After release, a new buffer_ready_i restarts from beat 0 granted to A.
6. With RAM_FRAME_ARB_WATCHDOG_EN and TIMEOUT_CYCLES=16, B stalls at beat 10 → timeout_o pulses after 16 stall cycles. The remaining 246 beats are drained, and the next grant goes to A.

Source files
------------

// File: rtl/ram_frame_arbiter_if.sv
// Bundle of RAM-side and consumer-side signals around the frame arbiter.
// slave = arbiter view, master = RAM/consumer (environment) view.
interface ram_frame_arbiter_if #(
  parameter int unsigned DATA_W = 32
);
  logic              buffer_ready_i;
  logic [DATA_W-1:0] ram_data_i;
  logic              ram_valid_i;
  logic              ram_ready_o;

  logic              a_req_i;
  logic              a_grant_o;
  logic [DATA_W-1:0] a_data_o;
  logic              a_valid_o;
  logic              a_ready_i;

  logic              b_req_i;
  logic              b_grant_o;
  logic [DATA_W-1:0] b_data_o;
  logic              b_valid_o;
  logic              b_ready_i;

  logic              frame_start_o;
  logic              frame_last_o;
  logic              frame_drop_o;
  logic [7:0]        drop_count_o;
  logic              busy_o;
  logic              timeout_o;

  modport slave (
    input  buffer_ready_i, ram_data_i, ram_valid_i,
    input  a_req_i, a_ready_i, b_req_i, b_ready_i,
    output ram_ready_o,
    output a_grant_o, a_data_o, a_valid_o,
    output b_grant_o, b_data_o, b_valid_o,
    output frame_start_o, frame_last_o, frame_drop_o, drop_count_o, busy_o, timeout_o
  );

  modport master (
    output buffer_ready_i, ram_data_i, ram_valid_i,
    output a_req_i, a_ready_i, b_req_i, b_ready_i,
    input  ram_ready_o,
    input  a_grant_o, a_data_o, a_valid_o,
    input  b_grant_o, b_data_o, b_valid_o,
    input  frame_start_o, frame_last_o, frame_drop_o, drop_count_o, busy_o, timeout_o
  );
endinterface

// File: rtl/ram_frame_arbiter.sv
// Round-robin whole-frame arbiter for the ping-pong RAM read port; unclaimed frames are drained.
// Optional stall watchdog: define RAM_FRAME_ARB_WATCHDOG_EN.
module ram_frame_arbiter #(
  parameter int unsigned FRAME_LEN      = 256,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input logic                clk_i,
  input logic                rst_ni,
  ram_frame_arbiter_if.slave bus
);

  localparam int unsigned CntW    = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(FRAME_LEN - 1);

  typedef enum logic [1:0] {StIdle, StArb, StStream, StDrain} state_e;

  state_e          state_q, state_d;
  logic            pending_q, pending_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            grant_a_q, grant_a_d;
  logic            grant_b_q, grant_b_d;
  logic            prefer_b_q, prefer_b_d;
  logic [7:0]      drop_cnt_q, drop_cnt_d;

  logic              busy, ram_ready, beat, frame_end;
  logic              drop_arb, drop_lost, stall_hit;
  logic [1:0]        n_drops;
  logic [8:0]        drop_sum;
  logic [DATA_W-1:0] ram_data;

  assign busy      = (state_q != StIdle);
  assign ram_ready = (state_q == StDrain) | (grant_a_q & bus.a_ready_i) |
                     (grant_b_q & bus.b_ready_i);
  assign beat      = bus.ram_valid_i & ram_ready;
  assign drop_lost = busy & bus.buffer_ready_i & pending_q;

`ifdef RAM_FRAME_ARB_WATCHDOG_EN
  localparam int unsigned StallW = $clog2(TIMEOUT_CYCLES + 1);
  logic [StallW-1:0] stall_q, stall_d;
  logic              stalled;

  assign stalled   = (state_q == StStream) & bus.ram_valid_i & ~ram_ready;
  assign stall_hit = stalled & (stall_q == StallW'(TIMEOUT_CYCLES - 1));
  // Any non-stall cycle (including every beat) restarts the count.
  assign stall_d   = (stalled & ~stall_hit) ? stall_q + StallW'(1) : '0;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) stall_q <= '0;
    else         stall_q <= stall_d;
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign stall_hit      = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    pending_d  = pending_q;
    cnt_d      = cnt_q;
    grant_a_d  = grant_a_q;
    grant_b_d  = grant_b_q;
    prefer_b_d = prefer_b_q;
    drop_arb   = 1'b0;
    frame_end  = 1'b0;

    if (busy && bus.buffer_ready_i && !pending_q) pending_d = 1'b1;

    unique case (state_q)
      StIdle: begin
        if (bus.buffer_ready_i || pending_q) begin
          state_d   = StArb;
          pending_d = 1'b0;
        end
      end
      StArb: begin
        if (bus.a_req_i && (!bus.b_req_i || !prefer_b_q)) begin
          grant_a_d = 1'b1;
          state_d   = StStream;
        end else if (bus.b_req_i) begin
          grant_b_d = 1'b1;
          state_d   = StStream;
        end else begin
          drop_arb = 1'b1;
          state_d  = StDrain;
        end
      end
      StStream, StDrain: begin
        if (beat) begin
          if (cnt_q == LastCnt) begin
            cnt_d     = '0;
            frame_end = 1'b1;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (frame_end) begin
      if (state_q == StStream) prefer_b_d = grant_a_q;
      grant_a_d = 1'b0;
      grant_b_d = 1'b0;
      // A buffer announced on the last beat is picked up here via pending_d.
      if (pending_d) begin
        state_d   = StArb;
        pending_d = 1'b0;
      end else begin
        state_d = StIdle;
      end
    end else if (stall_hit) begin
      prefer_b_d = grant_a_q;
      grant_a_d  = 1'b0;
      grant_b_d  = 1'b0;
      state_d    = StDrain;
    end
  end

  assign n_drops    = 2'(drop_arb) + 2'(drop_lost) + 2'(stall_hit);
  assign drop_sum   = {1'b0, drop_cnt_q} + {7'd0, n_drops};
  assign drop_cnt_d = drop_sum[8] ? 8'hff : drop_sum[7:0];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      pending_q  <= 1'b0;
      cnt_q      <= '0;
      grant_a_q  <= 1'b0;
      grant_b_q  <= 1'b0;
      prefer_b_q <= 1'b0;
      drop_cnt_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      cnt_q      <= cnt_d;
      grant_a_q  <= grant_a_d;
      grant_b_q  <= grant_b_d;
      prefer_b_q <= prefer_b_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign ram_data          = bus.ram_data_i;
  assign bus.a_data_o      = ram_data;
  assign bus.b_data_o      = ram_data;
  assign bus.ram_ready_o   = ram_ready;
  assign bus.a_grant_o     = grant_a_q;
  assign bus.b_grant_o     = grant_b_q;
  assign bus.a_valid_o     = grant_a_q & bus.ram_valid_i;
  assign bus.b_valid_o     = grant_b_q & bus.ram_valid_i;
  assign bus.frame_start_o = (state_q == StStream) & beat & (cnt_q == '0);
  assign bus.frame_last_o  = (state_q == StStream) & beat & (cnt_q == LastCnt);
  assign bus.frame_drop_o  = |n_drops;
  assign bus.drop_count_o  = drop_cnt_q;
  assign bus.busy_o        = busy;
  assign bus.timeout_o     = stall_hit;

endmodule
